legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle LEGv8 datapath.
- Sequences fetch, decode, execute, memory and writeback for ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B.
- Drives ALUOp into the existing ALU control decoder, plus all mux, register-enable and memory strobes.
- Waits on a shared-memory ready handshake and halts with a fault code on an illegal opcode or memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_ready in any memory state before a fault.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start request, sampled in IDLE.
- instr  in  32  current IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completed the current access this cycle.
- ALUOp  out  2  to ALU control: 00 add, 01 pass-B/CBZ, 10 R-type funct.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 reg A, 10 OldPC.
- ALUSrcB  out  2  ALU B select: 00 reg B, 01 const 4, 10 sext DT address, 11 sext branch offset shifted left 2.
- PCSource  out  1  PC input: 0 ALU result, 1 ALUOut.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write if ALU zero.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR and OldPC.
- Reg2Loc  out  1  register-read-2 select.
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback select: 0 ALUOut, 1 MDR.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  FSM is in HALT.
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- Reset, asynchronous: state=IDLE, wait counter=0, fault=00. All outputs 0 immediately on reset assertion, including mid-instruction. Nothing is flushed in the datapath.
- Outputs are a Moore decode of the state only; Reg2Loc is the exception (see below). Any output not listed for a state is 0.
- Opcode classes from instr:
  - R-type: [31:21] = 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
  - Data transfer: [31:21] = 11111000010 LDUR, 11111000000 STUR.
  - CBZ: [31:24] = 10110100.
  - B: [31:26] = 000101.
- Reg2Loc = 1 when instr is STUR or CBZ, in any state except IDLE and HALT.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite and PCWrite equal mem_ready.
  - Leave for DECODE only on mem_ready=1.
- DECODE: ALUSrcA=10, ALUSrcB=11, ALUOp=00, so ALUOut holds the branch target. Next state by class:
  - R-type to EXEC_R.
  - LDUR or STUR to MEM_ADDR.
  - CBZ to CBZ_EX.
  - B to B_EX.
  - Anything else to HALT with fault=01.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next R_WB.
- R_WB: RegWrite=1, MemtoReg=0, retired=1. Next FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: MemRead=1, IorD=1. Next LD_WB on mem_ready.
- LD_WB: RegWrite=1, MemtoReg=1, retired=1. Next FETCH.
- MEM_WR: MemWrite=1, IorD=1. On mem_ready: retired=1 and next FETCH.
- CBZ_EX: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, retired=1. Next FETCH.
- B_EX: PCWrite=1, PCSource=1, retired=1. Next FETCH.
- HALT: all control outputs 0, halted=1. fault holds its value. Exit only by reset; run is ignored.
- Timeout counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - Counter reaching MEM_TIMEOUT with mem_ready=0 sends the FSM to HALT with fault=10.
  - mem_ready=1 in that same cycle wins: normal transition, no fault.
- run is ignored outside IDLE. The FSM never returns to IDLE except via reset.
- Cycle counts with mem_ready always 1:
  - R-type 4.
  - LDUR 5.
  - STUR 4.
  - CBZ and B 3.

Test Plan:
- Reset, run=1, mem_ready=1, instr=ADD (0x8B020020) -> states IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH. ALUOp=10 in EXEC_R; RegWrite=1 and retired=1 only in R_WB.
- LDUR with mem_ready low for 3 cycles in MEM_RD -> MemRead=1 and IorD=1 held 4 cycles. LD_WB follows with MemtoReg=1. Total 8 cycles, fault=00.
- STUR then CBZ -> Reg2Loc=1 from DECODE on. CBZ_EX shows ALUOp=01, PCWriteCond=1, PCSource=1. B shows PCWrite=1 in B_EX after 3 cycles.
- instr=0xFFFFFFFF -> HALT after DECODE, fault=01, halted=1. Pulse run: still halted. Reset clears to IDLE with fault=00.
- MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH -> HALT at the 16th wait cycle, fault=10. Repeat with mem_ready=1 in that 16th cycle -> DECODE, no fault.
- Assert rst_n=0 mid-MEM_WR -> MemWrite and all outputs drop to 0 in the same cycle without waiting for a clock edge. State is IDLE after release.

Source files
------------

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multi-cycle LEGv8 datapath.
// Sequences fetch / decode / execute / memory / writeback for ADD, SUB, AND, ORR,
// LDUR, STUR, CBZ and B. It waits on a shared-memory ready handshake. On an
// illegal opcode or a memory timeout it halts and reports a fault code.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   run               start request, only looked at in IDLE
//   instr             IR contents, valid from DECODE onward
//   mem_ready         memory finished the current access this cycle
//   ALUOp..MemtoReg   datapath mux selects, register enables and memory strobes
//   retired           one-cycle pulse per completed instruction
//   halted            FSM sits in HALT
//   fault             00 none, 01 illegal opcode, 10 memory timeout
module legv8_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        retired,
  output logic        halted,
  output logic [1:0]  fault
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StRWb, StMemAddr,
    StMemRd, StLdWb, StMemWr, StCbzEx, StBEx, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        fault_q, fault_d;

  // Opcode classes
  logic [10:0] op11;
  logic        is_rtype, is_ldur, is_stur, is_cbz, is_b;
  logic        unused_instr;

  assign op11         = instr[31:21];
  assign is_rtype     = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
                        (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
  assign is_ldur      = (op11 == 11'b11111000010);
  assign is_stur      = (op11 == 11'b11111000000);
  assign is_cbz       = (instr[31:24] == 8'b10110100);
  assign is_b         = (instr[31:26] == 6'b000101);
  assign unused_instr = ^instr[20:0];

  // Memory wait tracking: the timeout fires in the cycle the count would reach
  // MEM_TIMEOUT, so the FSM leaves after exactly MEM_TIMEOUT unanswered cycles.
  logic mem_wait, timeout;
  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout  = mem_wait && !mem_ready && (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle:    if (run) state_d = StFetch;
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else if (timeout) begin
          state_d = StHalt;
          fault_d = 2'b10;
        end
      end
      StDecode: begin
        if (is_rtype)                state_d = StExecR;
        else if (is_ldur || is_stur) state_d = StMemAddr;
        else if (is_cbz)             state_d = StCbzEx;
        else if (is_b)               state_d = StBEx;
        else begin
          state_d = StHalt;
          fault_d = 2'b01;
        end
      end
      StExecR:   state_d = StRWb;
      StRWb:     state_d = StFetch;
      StMemAddr: state_d = is_stur ? StMemWr : StMemRd;
      StMemRd, StMemWr: begin
        if (mem_ready) state_d = (state_q == StMemRd) ? StLdWb : StFetch;
        else if (timeout) begin
          state_d = StHalt;
          fault_d = 2'b10;
        end
      end
      StLdWb:    state_d = StFetch;
      StCbzEx:   state_d = StFetch;
      StBEx:     state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
    // Count only while stalled in the same wait state; any transition clears it.
    cnt_d = (mem_wait && !mem_ready && (state_d == state_q)) ? cnt_q + TO_W'(1) : '0;
  end

  // Output decode
  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    retired     = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        // ALUOut captures OldPC + branch offset for CBZ/B
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b11;
      end
      StExecR: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      StRWb: begin
        RegWrite = 1'b1;
        retired  = 1'b1;
      end
      StMemAddr: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StLdWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retired  = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retired  = mem_ready;
      end
      StCbzEx: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retired     = 1'b1;
      end
      StBEx: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        retired  = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign Reg2Loc = (is_stur || is_cbz) && (state_q != StIdle) && (state_q != StHalt);
  assign fault   = fault_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
module tb_legv8_multicycle_ctrl;

  localparam int unsigned MemTimeout = 16;

  localparam logic [31:0] I_ADD  = 32'h8B020020;
  localparam logic [31:0] I_SUB  = 32'hCB020020;
  localparam logic [31:0] I_ORR  = 32'hAA020020;
  localparam logic [31:0] I_LDUR = 32'hF8400041;
  localparam logic [31:0] I_STUR = 32'hF8000041;
  localparam logic [31:0] I_CBZ  = 32'hB4000040;
  localparam logic [31:0] I_B    = 32'h14000004;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_EXR = 3, S_RWB = 4, S_MADDR = 5,
                 S_MRD = 6, S_LDWB = 7, S_MWR = 8, S_CBZ = 9, S_BEX = 10, S_HALT = 11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_src;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg2loc;
    logic       reg_wr;
    logic       mem2reg;
    logic       retired;
    logic       halted;
    logic [1:0] fault;
  } ctrl_t;

  typedef struct {
    logic        run;
    logic [31:0] instr;
    logic        mr;
    ctrl_t       exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  ctrl_t       act;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(MemTimeout), .TO_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .ALUOp      (act.alu_op),
    .ALUSrcA    (act.src_a),
    .ALUSrcB    (act.src_b),
    .PCSource   (act.pc_src),
    .PCWrite    (act.pc_wr),
    .PCWriteCond(act.pc_wr_cond),
    .IorD       (act.iord),
    .MemRead    (act.mem_rd),
    .MemWrite   (act.mem_wr),
    .IRWrite    (act.ir_wr),
    .Reg2Loc    (act.reg2loc),
    .RegWrite   (act.reg_wr),
    .MemtoReg   (act.mem2reg),
    .retired    (act.retired),
    .halted     (act.halted),
    .fault      (act.fault)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  ctrl_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  // Expected control word for a state, straight from the state table.
  function automatic ctrl_t model(int st, logic mr, logic r2l, logic [1:0] flt);
    ctrl_t c = '0;
    c.fault = flt;
    if (st != S_IDLE && st != S_HALT) c.reg2loc = r2l;
    case (st)
      S_FETCH: begin c.mem_rd = 1; c.src_b = 2'b01; c.ir_wr = mr; c.pc_wr = mr; end
      S_DEC:   begin c.src_a = 2'b10; c.src_b = 2'b11; end
      S_EXR:   begin c.src_a = 2'b01; c.alu_op = 2'b10; end
      S_RWB:   begin c.reg_wr = 1; c.retired = 1; end
      S_MADDR: begin c.src_a = 2'b01; c.src_b = 2'b10; end
      S_MRD:   begin c.mem_rd = 1; c.iord = 1; end
      S_LDWB:  begin c.reg_wr = 1; c.mem2reg = 1; c.retired = 1; end
      S_MWR:   begin c.mem_wr = 1; c.iord = 1; c.retired = mr; end
      S_CBZ:   begin
        c.src_a = 2'b01; c.alu_op = 2'b01; c.pc_wr_cond = 1; c.pc_src = 1; c.retired = 1;
      end
      S_BEX:   begin c.pc_wr = 1; c.pc_src = 1; c.retired = 1; end
      S_HALT:  c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic void addv(logic r, logic [31:0] ins, logic mr, int st, logic r2l,
                               logic [1:0] flt, string nm);
    vec_t v;
    v.run = r; v.instr = ins; v.mr = mr; v.exp = model(st, mr, r2l, flt); v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check();
    ctrl_t e;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, required an expected entry", act);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, e);
    end
  endtask

  // Apply one cycle of inputs, compare mid-cycle, then advance past the edge.
  task automatic step(logic r, logic [31:0] ins, logic mr, ctrl_t e, string nm);
    run = r; instr = ins; mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #2;
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model(S_IDLE, 0, 0, 2'b00));
    name_q.push_back("reset_state");
    check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: ADD, SUB with a fetch stall, LDUR with 3 stalls, STUR, CBZ, B, ORR, illegal.
    addv(0, I_ADD, 1, S_IDLE,  0, 2'b00, "idle_no_run");
    addv(1, I_ADD, 1, S_IDLE,  0, 2'b00, "idle_run");
    addv(0, I_ADD, 1, S_FETCH, 0, 2'b00, "add_fetch");
    addv(0, I_ADD, 1, S_DEC,   0, 2'b00, "add_decode");
    addv(0, I_ADD, 1, S_EXR,   0, 2'b00, "add_exec");
    addv(0, I_ADD, 1, S_RWB,   0, 2'b00, "add_wb");
    addv(0, I_SUB, 0, S_FETCH, 0, 2'b00, "sub_fetch_stall");
    addv(0, I_SUB, 1, S_FETCH, 0, 2'b00, "sub_fetch");
    addv(0, I_SUB, 1, S_DEC,   0, 2'b00, "sub_decode");
    addv(0, I_SUB, 1, S_EXR,   0, 2'b00, "sub_exec");
    addv(0, I_SUB, 1, S_RWB,   0, 2'b00, "sub_wb");
    addv(0, I_LDUR, 1, S_FETCH, 0, 2'b00, "ldur_fetch");
    addv(0, I_LDUR, 1, S_DEC,   0, 2'b00, "ldur_decode");
    addv(0, I_LDUR, 1, S_MADDR, 0, 2'b00, "ldur_addr");
    for (int i = 0; i < 3; i++) addv(0, I_LDUR, 0, S_MRD, 0, 2'b00, "ldur_rd_stall");
    addv(0, I_LDUR, 1, S_MRD,   0, 2'b00, "ldur_rd");
    addv(0, I_LDUR, 1, S_LDWB,  0, 2'b00, "ldur_wb");
    addv(0, I_STUR, 1, S_FETCH, 1, 2'b00, "stur_fetch");
    addv(0, I_STUR, 1, S_DEC,   1, 2'b00, "stur_decode");
    addv(0, I_STUR, 1, S_MADDR, 1, 2'b00, "stur_addr");
    addv(0, I_STUR, 1, S_MWR,   1, 2'b00, "stur_wr");
    addv(0, I_CBZ, 1, S_FETCH, 1, 2'b00, "cbz_fetch");
    addv(0, I_CBZ, 1, S_DEC,   1, 2'b00, "cbz_decode");
    addv(0, I_CBZ, 1, S_CBZ,   1, 2'b00, "cbz_ex");
    addv(0, I_B,   1, S_FETCH, 0, 2'b00, "b_fetch");
    addv(0, I_B,   1, S_DEC,   0, 2'b00, "b_decode");
    addv(0, I_B,   1, S_BEX,   0, 2'b00, "b_ex");
    addv(0, I_ORR, 1, S_FETCH, 0, 2'b00, "orr_fetch");
    addv(0, I_ORR, 1, S_DEC,   0, 2'b00, "orr_decode");
    addv(0, I_ORR, 1, S_EXR,   0, 2'b00, "orr_exec");
    addv(0, I_ORR, 1, S_RWB,   0, 2'b00, "orr_wb");
    addv(0, I_BAD, 1, S_FETCH, 0, 2'b00, "bad_fetch");
    addv(0, I_BAD, 1, S_DEC,   0, 2'b00, "bad_decode");
    addv(0, I_BAD, 1, S_HALT,  0, 2'b01, "bad_halt");
    addv(1, I_BAD, 1, S_HALT,  0, 2'b01, "halt_run_ignored");
    addv(0, I_ADD, 1, S_HALT,  0, 2'b01, "halt_sticky");

    do_reset();
    foreach (vecs[i]) step(vecs[i].run, vecs[i].instr, vecs[i].mr, vecs[i].exp, vecs[i].name);
    do_reset();
    step(1, I_ADD, 1, model(S_IDLE, 0, 0, 2'b00), "post_halt_idle");

    // Fetch timeout: 16 unanswered cycles halt with fault 10.
    do_reset();
    step(1, I_ADD, 0, model(S_IDLE, 0, 0, 2'b00), "to_idle");
    for (int i = 0; i < MemTimeout; i++)
      step(0, I_ADD, 0, model(S_FETCH, 0, 0, 2'b00), "to_fetch_wait");
    step(0, I_ADD, 0, model(S_HALT, 0, 0, 2'b10), "to_halt");

    // mem_ready in the 16th cycle wins over the timeout.
    do_reset();
    step(1, I_ADD, 0, model(S_IDLE, 0, 0, 2'b00), "win_idle");
    for (int i = 0; i < MemTimeout - 1; i++)
      step(0, I_ADD, 0, model(S_FETCH, 0, 0, 2'b00), "win_fetch_wait");
    step(0, I_ADD, 1, model(S_FETCH, 1, 0, 2'b00), "win_fetch_ready");
    step(0, I_ADD, 1, model(S_DEC, 1, 0, 2'b00), "win_decode");

    // Asynchronous reset in the middle of a stalled store.
    do_reset();
    step(1, I_STUR, 1, model(S_IDLE, 0, 0, 2'b00), "ar_idle");
    step(0, I_STUR, 1, model(S_FETCH, 1, 1, 2'b00), "ar_fetch");
    step(0, I_STUR, 1, model(S_DEC, 1, 1, 2'b00), "ar_decode");
    step(0, I_STUR, 1, model(S_MADDR, 1, 1, 2'b00), "ar_addr");
    step(0, I_STUR, 0, model(S_MWR, 0, 1, 2'b00), "ar_memwr");
    exp_q.push_back(model(S_MWR, 0, 1, 2'b00));
    name_q.push_back("ar_memwr_hold");
    #1;
    check();
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model(S_IDLE, 0, 0, 2'b00));
    name_q.push_back("ar_async_drop");
    check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, I_STUR, 1, model(S_IDLE, 0, 0, 2'b00), "ar_after_idle");
    step(0, I_STUR, 1, model(S_FETCH, 1, 1, 2'b00), "ar_after_fetch");

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
